fifo_upsizer: RTL

Stream width upsizer between two FWFT FIFOs. It drains narrow words from an upstream FIFO read port and packs RATIO consecutive words into one wide word. It presents the wide word to a downstream FIFO write port. It sustains one narrow word per cycle when the downstream FIFO is not full.

---
 rtl/fifo_upsizer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fifo_upsizer.sv
// fifo_upsizer
// Packs RATIO consecutive narrow words drained from an upstream FWFT FIFO
// into one wide word presented to a downstream FIFO write port. Lane 0 of the
// wide word is the first narrow word received.
//
// Optional feature: define FIFO_UPSIZER_FLUSH_EN to honour the flush input.
// When enabled, a flush request is held sticky and emits the partial wide
// word, with out_keep marking only the lanes that were filled. When disabled,
// flush is ignored and out_keep is all ones after the first output.

module fifo_upsizer #(
    parameter int IN_WIDTH  = 32,
    parameter int RATIO     = 4,
    parameter int OUT_WIDTH = IN_WIDTH * RATIO,
    parameter int CNT_WIDTH = $clog2(RATIO) + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_empty_n,
    input  logic [IN_WIDTH-1:0]  in_dout,
    output logic                 in_read,
    input  logic                 out_full_n,
    output logic                 out_write,
    output logic [OUT_WIDTH-1:0] out_din,
    output logic [RATIO-1:0]     out_keep,
    input  logic                 flush
);

    // Packing state: next lane to fill, partial wide word and its lane mask.
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [OUT_WIDTH-1:0] r_acc;
    logic [RATIO-1:0]     r_kacc;

    // Output register toward the downstream FIFO.
    logic                 r_outWrite;
    logic [OUT_WIDTH-1:0] r_outDin;
    logic [RATIO-1:0]     r_outKeep;

    // Handshake terms.
    logic                 w_drain;
    logic                 w_outFree;
    logic                 w_lastLane;
    logic                 w_accept;
    logic                 w_complete;
    logic                 w_load;

    // Accumulator and mask with the word accepted this cycle already merged.
    logic [OUT_WIDTH-1:0] w_accNext;
    logic [RATIO-1:0]     w_kaccNext;
    logic [RATIO-1:0]     w_keepLoad;

    // The output register is free when it is empty or being drained now.
    assign w_drain    = r_outWrite & out_full_n;
    assign w_outFree  = ~r_outWrite | out_full_n;
    assign w_lastLane = (r_cnt == CNT_WIDTH'(RATIO - 1));

    // Lanes 0..RATIO-2 can always be filled; the last lane needs the output
    // register to be free because filling it loads the output register.
    assign w_accept   = in_empty_n & (~w_lastLane | w_outFree);
    assign w_complete = w_accept & w_lastLane;
    assign in_read    = w_accept;

`ifdef FIFO_UPSIZER_FLUSH_EN
    // Sticky flush request and the two ways it is retired.
    logic r_flushPending;
    logic w_flushService;
    logic w_flushDrop;

    // A pending flush emits whatever is packed (including this cycle's word)
    // once the output register is free; with nothing packed it just retires.
    assign w_flushService = r_flushPending & w_outFree & ((r_cnt != '0) | w_accept);
    assign w_flushDrop    = r_flushPending & (r_cnt == '0) & ~w_accept;
    assign w_load         = w_complete | w_flushService;

    // Hold the flush request until it has been serviced or found empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flushPending <= 1'b0;
        end else begin
            r_flushPending <= flush | (r_flushPending & ~w_flushService & ~w_flushDrop);
        end
    end
`else
    // Flush is not supported in this build; keep the port tied off quietly.
    logic w_unusedFlush;
    assign w_unusedFlush = flush;
    assign w_load        = w_complete;
`endif

    // Merge the accepted narrow word into its lane of the accumulator.
    always_comb begin
        w_accNext  = r_acc;
        w_kaccNext = r_kacc;
        for (int i = 0; i < RATIO; i++) begin
            if (w_accept && (r_cnt == CNT_WIDTH'(i))) begin
                w_accNext[i*IN_WIDTH +: IN_WIDTH] = in_dout;
                w_kaccNext[i]                     = 1'b1;
            end
        end
    end

    // A full word always carries an all-ones mask; a flushed word carries the
    // lanes filled so far.
    assign w_keepLoad = w_complete ? {RATIO{1'b1}} : w_kaccNext;

    // Packing state: clear on every load, otherwise advance one lane per accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_kacc <= '0;
        end else if (w_load) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_kacc <= '0;
        end else if (w_accept) begin
            r_cnt  <= r_cnt + CNT_WIDTH'(1);
            r_acc  <= w_accNext;
            r_kacc <= w_kaccNext;
        end
    end

    // Output register: a load wins over a drain so back-to-back words need no
    // bubble; data and mask hold their last value after a drain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_outWrite <= 1'b0;
            r_outDin   <= '0;
            r_outKeep  <= '0;
        end else if (w_load) begin
            r_outWrite <= 1'b1;
            r_outDin   <= w_accNext;
            r_outKeep  <= w_keepLoad;
        end else if (w_drain) begin
            r_outWrite <= 1'b0;
        end
    end

    assign out_write = r_outWrite;
    assign out_din   = r_outDin;
    assign out_keep  = r_outKeep;

endmodule
